// File: rtl/haraka_s_ctrl_pkg.sv
// Shared Haraka definitions: widths, controller state encoding and the
// digest truncation used by both the 512- and 256-bit controllers.
package haraka_pkg;

  localparam int STATE_W  = 512;
  localparam int DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ctrl_state_e;

  // Keeps bytes 8-15, 24-31, 32-39 and 48-55 (byte 0 sits at [511:504]).
  function automatic logic [DIGEST_W-1:0] haraka_trunc(input logic [STATE_W-1:0] s);
    return {s[447:384], s[319:256], s[255:192], s[127:64]};
  endfunction

endpackage

// File: rtl/haraka_s_ctrl_if.sv
// Block-in / result-out handshake bundle for the Haraka-512 round sequencer.
interface haraka_s_ctrl_if;
  import haraka_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [STATE_W-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [STATE_W-1:0]  out_state;
  logic [DIGEST_W-1:0] out_digest;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_state, out_digest
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_state, out_digest
  );

endinterface

// File: rtl/haraka_s_ctrl.sv
// Haraka-512 round sequencer: drives an external fixed-latency round datapath
// NUM_ROUNDS times per block, then applies feed-forward and truncation.
module haraka_s_ctrl
  import haraka_pkg::*;
#(
  parameter int NUM_ROUNDS    = 5,
  parameter int ROUND_LATENCY = 2,
  parameter bit FEED_FORWARD  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  haraka_s_ctrl_if.slave             bus,
  output logic                       dp_valid,
  output logic [STATE_W-1:0]         dp_in,
  output logic [$clog2(NUM_ROUNDS):0] dp_round,
  input  logic [STATE_W-1:0]         dp_out,
  output logic                       busy
);

  localparam int RW = $clog2(NUM_ROUNDS) + 1;
  localparam int CW = $clog2(ROUND_LATENCY + 1) + 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0] WAIT_INIT  = CW'(ROUND_LATENCY);

  ctrl_state_e        state, state_nxt;
  logic [STATE_W-1:0] st, x_reg, out_state_r, dp_hold;
  logic [RW-1:0]      round;
  logic [CW-1:0]      wait_cnt;
  logic               capture, last_round;

  assign capture    = (state == WAIT) && (wait_cnt == CW'(1));
  assign last_round = (round == LAST_ROUND);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (capture)       state_nxt = last_round ? DONE : ISSUE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // wait_cnt is only armed by ISSUE, so a datapath result still in flight
  // from a discarded message can never line up with a capture cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= '0;
      x_reg       <= '0;
      out_state_r <= '0;
      dp_hold     <= '0;
      round       <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            st    <= bus.in_data;
            x_reg <= bus.in_data;
            round <= '0;
          end
        end
        ISSUE: begin
          dp_hold  <= st;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (capture) begin
            st    <= dp_out;
            round <= round + RW'(1);
            if (last_round)
              out_state_r <= FEED_FORWARD ? (dp_out ^ x_reg) : dp_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = rst_n && (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_state  = out_state_r;
  assign bus.out_digest = haraka_trunc(out_state_r);
  assign dp_valid       = (state == ISSUE);
  assign dp_in          = (state == ISSUE) ? st : dp_hold;
  assign dp_round       = round;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_haraka_s_ctrl.sv
// Directed bench for haraka_s_ctrl using rotate/identity stub datapaths on
// three configurations (defaults, FEED_FORWARD=0, one round of latency one).
module tb_haraka_s_ctrl;
  import haraka_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [STATE_W-1:0] WORDS = {
    64'h0000_0000_0000_0000, 64'h1111_1111_1111_1111,
    64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333,
    64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555,
    64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777};

  haraka_s_ctrl_if bus_a();
  haraka_s_ctrl_if bus_b();
  haraka_s_ctrl_if bus_c();

  logic               dp_valid_a, dp_valid_b, dp_valid_c;
  logic               busy_a, busy_b, busy_c;
  logic [STATE_W-1:0] dp_in_a, dp_in_b, dp_in_c;
  logic [STATE_W-1:0] dp_out_a, dp_out_b, dp_out_c;
  logic [3:0]         dp_round_a, dp_round_b;
  logic [0:0]         dp_round_c;

  haraka_s_ctrl #(.NUM_ROUNDS(5), .ROUND_LATENCY(2), .FEED_FORWARD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .dp_valid(dp_valid_a),
    .dp_in(dp_in_a), .dp_round(dp_round_a), .dp_out(dp_out_a), .busy(busy_a));

  haraka_s_ctrl #(.NUM_ROUNDS(5), .ROUND_LATENCY(2), .FEED_FORWARD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .dp_valid(dp_valid_b),
    .dp_in(dp_in_b), .dp_round(dp_round_b), .dp_out(dp_out_b), .busy(busy_b));

  haraka_s_ctrl #(.NUM_ROUNDS(1), .ROUND_LATENCY(1), .FEED_FORWARD(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave), .dp_valid(dp_valid_c),
    .dp_in(dp_in_c), .dp_round(dp_round_c), .dp_out(dp_out_c), .busy(busy_c));

  // Stub datapaths sample dp_in every cycle; only the capture cycle should matter.
  logic stub_rot_a = 1'b1;
  logic [STATE_W-1:0] pipe_a0 = '0, pipe_a1 = '0, pipe_b0 = '0, pipe_b1 = '0, pipe_c0 = '0;
  always @(posedge clk) begin
    pipe_a0 <= stub_rot_a ? {dp_in_a[510:0], dp_in_a[511]} : dp_in_a;
    pipe_a1 <= pipe_a0;
    pipe_b0 <= dp_in_b;
    pipe_b1 <= pipe_b0;
    pipe_c0 <= {dp_in_c[510:0], dp_in_c[511]};
  end
  assign dp_out_a = pipe_a1;
  assign dp_out_b = pipe_b1;
  assign dp_out_c = pipe_c0;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Logs, by edge number, accepts and round issues that the next edge will see.
  int acc_q[$];
  int dp_edge_q[$];
  int dp_round_q[$];
  int dp_cnt_c = 0;
  always begin
    @(negedge clk); #1;
    if (bus_a.in_valid && bus_a.in_ready) acc_q.push_back(cycle + 1);
    if (dp_valid_a) begin
      dp_edge_q.push_back(cycle + 1);
      dp_round_q.push_back(int'(dp_round_a));
    end
    if (dp_valid_c) dp_cnt_c++;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [STATE_W-1:0] got,
                             input logic [STATE_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic readyOf(input int which);
    case (which)
      0:       return bus_a.in_ready;
      1:       return bus_b.in_ready;
      default: return bus_c.in_ready;
    endcase
  endfunction

  function automatic logic validOf(input int which);
    case (which)
      0:       return bus_a.out_valid;
      1:       return bus_b.out_valid;
      default: return bus_c.out_valid;
    endcase
  endfunction

  task automatic driveIn(input int which, input logic v, input logic [STATE_W-1:0] d);
    case (which)
      0:       begin bus_a.in_valid = v; bus_a.in_data = d; end
      1:       begin bus_b.in_valid = v; bus_b.in_data = d; end
      default: begin bus_c.in_valid = v; bus_c.in_data = d; end
    endcase
  endtask

  task automatic applyStimulus(input int which, input logic [STATE_W-1:0] data, output int acc);
    int n = 0;
    @(negedge clk);
    driveIn(which, 1'b1, data);
    #1;
    while (!readyOf(which) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("accept_wait", n < 100, 1'b1);
    acc = cycle + 1;
    @(negedge clk);
    driveIn(which, 1'b0, '0);
  endtask

  task automatic waitValid(input int which, output int rise);
    int n = 0;
    while (!validOf(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("out_valid_wait", n < 200, 1'b1);
    rise = cycle + 1;
  endtask

  initial begin
    int acc, rise, base, cnt, n, cnt0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", bus_a.in_ready, 1'b0);
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_out_valid", bus_a.out_valid, 1'b0);
    checkOutput("rst_dp_valid", dp_valid_a, 1'b0);
    checkOutput("rst_out_state", bus_a.out_state, '0);
    checkOutput("rst_dp_in", dp_in_a, '0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", bus_a.in_ready, 1'b1);

    // Rotate stub: five 1-bit rotations plus feed-forward.
    bus_a.out_ready = 1'b1;
    applyStimulus(0, 512'h1 << 64, acc);
    waitValid(0, rise);
    checkOutput("rot_latency", rise - acc, 16);
    checkOutput("rot_state", bus_a.out_state, (512'h1 << 69) | (512'h1 << 64));
    checkOutput("rot_digest", bus_a.out_digest, 256'h21);

    // Identity stub with feed-forward cancels the input.
    stub_rot_a = 1'b0;
    applyStimulus(0, WORDS ^ 512'hDEAD_BEEF_0123_4567, acc);
    waitValid(0, rise);
    checkOutput("ident_ff_state", bus_a.out_state, '0);
    checkOutput("ident_ff_digest", bus_a.out_digest, '0);
    stub_rot_a = 1'b1;

    // Identity stub without feed-forward returns the input.
    bus_b.out_ready = 1'b1;
    applyStimulus(1, WORDS, acc);
    waitValid(1, rise);
    checkOutput("noff_latency", rise - acc, 16);
    checkOutput("noff_state", bus_b.out_state, WORDS);
    checkOutput("noff_digest", bus_b.out_digest,
                {64'h1111_1111_1111_1111, 64'h3333_3333_3333_3333,
                 64'h4444_4444_4444_4444, 64'h6666_6666_6666_6666});

    // Consumer stall.
    bus_a.out_ready = 1'b0;
    applyStimulus(0, 512'h1 << 64, acc);
    waitValid(0, rise);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", bus_a.out_valid, 1'b1);
      checkOutput("stall_out_state", bus_a.out_state, (512'h1 << 69) | (512'h1 << 64));
      checkOutput("stall_in_ready", bus_a.in_ready, 1'b0);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", bus_a.in_ready, 1'b1);
    checkOutput("release_out_valid", bus_a.out_valid, 1'b0);

    // Back-to-back blocks with in_valid held high.
    base = acc_q.size();
    bus_a.in_data = 512'h1 << 64;
    bus_a.in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < base + 3 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checkOutput("b2b_accepts", acc_q.size() >= base + 3, 1'b1);
    if (acc_q.size() >= base + 3) begin
      checkOutput("b2b_gap0", acc_q[base+1] - acc_q[base], 17);
      checkOutput("b2b_gap1", acc_q[base+2] - acc_q[base+1], 17);
      cnt = 0;
      foreach (dp_edge_q[k]) begin
        if (dp_edge_q[k] > acc_q[base] && dp_edge_q[k] < acc_q[base+1]) begin
          checkOutput("b2b_dp_round", dp_round_q[k], cnt);
          checkOutput("b2b_dp_edge", dp_edge_q[k] - acc_q[base], 1 + 3 * cnt);
          cnt++;
        end
      end
      checkOutput("b2b_dp_count", cnt, 5);
    end
    repeat (25) @(negedge clk);

    // Reset while round 3 is in flight.
    applyStimulus(0, 512'hFFFF_0000_FFFF, acc);
    n = 0;
    while (!(dp_valid_a && dp_round_a == 4'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("round3_wait", n < 100, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", busy_a, 1'b0);
    checkOutput("midrst_out_valid", bus_a.out_valid, 1'b0);
    checkOutput("midrst_dp_valid", dp_valid_a, 1'b0);
    checkOutput("midrst_in_ready", bus_a.in_ready, 1'b0);
    checkOutput("midrst_out_state", bus_a.out_state, '0);
    checkOutput("midrst_dp_in", dp_in_a, '0);
    checkOutput("midrst_dp_round", dp_round_a, 4'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_idle_ready", bus_a.in_ready, 1'b1);
    applyStimulus(0, 512'h1 << 200, acc);
    waitValid(0, rise);
    checkOutput("fresh_latency", rise - acc, 16);
    checkOutput("fresh_state", bus_a.out_state, (512'h1 << 205) | (512'h1 << 200));
    checkOutput("fresh_digest", bus_a.out_digest, 256'h2100 << 64);

    // Single round, latency one.
    cnt0 = dp_cnt_c;
    bus_c.out_ready = 1'b1;
    applyStimulus(2, 512'h1 << 64, acc);
    waitValid(2, rise);
    checkOutput("one_latency", rise - acc, 3);
    checkOutput("one_state", bus_c.out_state, (512'h1 << 65) | (512'h1 << 64));
    checkOutput("one_digest", bus_c.out_digest, 256'h3);
    repeat (4) @(negedge clk);
    checkOutput("one_dp_pulses", dp_cnt_c - cnt0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
